// File: rtl/snek_input_ctrl_if.sv
// snek_input_ctrl_if: button/step inputs and direction/press outputs of the snek input stage
interface snek_input_ctrl_if;
   logic [3:0] buttons;
   logic       step;
   logic       game_rst;
   logic [1:0] dir;
   logic [3:0] pressed;
   logic [3:0] press_pulse;
   logic       any_press;
   modport master (output buttons, step, game_rst, input dir, pressed, press_pulse, any_press);
   modport slave (input buttons, step, game_rst, output dir, pressed, press_pulse, any_press);
endinterface

// File: rtl/snek_input_ctrl.sv
// snek_input_ctrl: sync + debounce buttons, turn presses into a tick-committed, non-reversing direction
module snek_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 20
) (
   input logic               clk,
   input logic               rst,
   snek_input_ctrl_if.slave  bus
);
   logic [3:0]       r_sync1, r_sync2, r_pressed, r_pulse;
   logic             r_any;
   logic [CNT_W-1:0] r_cnt [4];
   logic [3:0]       w_mismatch, w_toggle, w_rise;
   logic             r_pend_vld;
   logic [1:0]       r_pend_code, r_dir;
   logic             w_req_vld, w_accept;
   logic [1:0]       w_req_code;

   assign w_mismatch = r_sync2 ^ r_pressed;
   assign w_rise     = w_toggle & ~r_pressed;

   for (genvar g = 0; g < 4; g++) begin : g_deb
      assign w_toggle[g] = w_mismatch[g] && (r_cnt[g] == CNT_W'(DEBOUNCE_CYCLES - 1));
      always_ff @(posedge clk)
         if (rst || !w_mismatch[g] || w_toggle[g]) r_cnt[g] <= '0;
         else r_cnt[g] <= r_cnt[g] + CNT_W'(1);
   end

   always_ff @(posedge clk)
      if (rst) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_pressed <= '0;
         r_pulse   <= '0;
         r_any     <= 1'b0;
      end else begin
         r_sync1   <= bus.buttons;
         r_sync2   <= r_sync1;
         r_pressed <= r_pressed ^ w_toggle;
         r_pulse   <= w_rise;
         r_any     <= |w_rise;
      end

   // priority left > right > up > down
   assign w_req_vld  = |r_pulse;
   assign w_req_code = r_pulse[1] ? 2'd0 : r_pulse[0] ? 2'd1 : r_pulse[2] ? 2'd2 : 2'd3;
   assign w_accept   = bus.step && r_pend_vld && (r_pend_code != (r_dir ^ 2'b01));

   always_ff @(posedge clk)
      if (rst) begin
         r_dir       <= 2'd0;
         r_pend_vld  <= 1'b0;
         r_pend_code <= 2'd0;
      end else if (bus.game_rst) begin
         r_dir      <= 2'd0;
         r_pend_vld <= 1'b0;
      end else begin
         if (w_accept) r_dir <= r_pend_code;
         // a fresh request survives a same-edge step; the step consumed the old pending
         if (w_req_vld) begin
            r_pend_vld  <= 1'b1;
            r_pend_code <= w_req_code;
         end else if (bus.step) r_pend_vld <= 1'b0;
      end

   assign bus.dir         = r_dir;
   assign bus.pressed     = r_pressed;
   assign bus.press_pulse = r_pulse;
   assign bus.any_press   = r_any;
endmodule

// File: tb/tb_snek_input_ctrl.sv
// tb_snek_input_ctrl: directed checks of debounce, press pulses and direction commit with DEBOUNCE_CYCLES=4
module tb_snek_input_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   logic bad;
   snek_input_ctrl_if bus ();

   snek_input_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic press_release(input logic [3:0] mask);
      bus.buttons = mask;
      repeat (6) tick();
      bus.buttons = 4'b0000;
      repeat (6) tick();
   endtask

   task automatic do_step();
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
   endtask

   initial begin
      bus.buttons  = 4'b1111;
      bus.step     = 1'b0;
      bus.game_rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_pulse", {27'd0, bus.any_press, bus.press_pulse}, 32'h0);
      end
      chk("rst_dir", bus.dir, 2'd0);
      chk("rst_pressed", bus.pressed, 4'b0000);
      rst = 1'b0;
      bus.buttons = 4'b0000;
      repeat (8) tick();
      chk("idle_pressed", bus.pressed, 4'b0000);

      bus.buttons = 4'b0100;
      repeat (5) tick();
      chk("up_before", bus.pressed, 4'b0000);
      tick();
      chk("up_pressed", bus.pressed, 4'b0100);
      chk("up_pulse", bus.press_pulse, 4'b0100);
      chk("up_any", bus.any_press, 1'b1);
      tick();
      chk("up_pulse_end", bus.press_pulse, 4'b0000);
      chk("up_any_end", bus.any_press, 1'b0);
      chk("up_held", bus.pressed, 4'b0100);
      bus.buttons = 4'b0000;
      repeat (5) tick();
      chk("rel_before", bus.pressed, 4'b0100);
      tick();
      chk("rel_pressed", bus.pressed, 4'b0000);
      chk("rel_no_pulse", bus.press_pulse, 4'b0000);
      chk("pre_step_dir", bus.dir, 2'd0);
      do_step();
      chk("commit_up", bus.dir, 2'd2);

      bad = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.buttons[2] = ~bus.buttons[2];
         repeat (3) begin
            tick();
            if (bus.pressed != 4'b0000 || bus.press_pulse != 4'b0000) bad = 1'b1;
         end
      end
      repeat (6) tick();
      chk("bounce", bad, 1'b0);

      press_release(4'b1000);
      do_step();
      chk("reverse_rej", bus.dir, 2'd2);
      do_step();
      chk("reverse_hold", bus.dir, 2'd2);

      bus.buttons = 4'b1010;
      repeat (6) tick();
      chk("prio_pulse", bus.press_pulse, 4'b1010);
      bus.buttons = 4'b0000;
      repeat (6) tick();
      do_step();
      chk("prio_left", bus.dir, 2'd0);

      press_release(4'b0001);
      press_release(4'b0100);
      do_step();
      chk("last_wins_up", bus.dir, 2'd2);
      press_release(4'b0100);
      press_release(4'b0001);
      do_step();
      chk("last_wins_right", bus.dir, 2'd1);

      press_release(4'b0100);
      bus.buttons = 4'b0001;
      repeat (6) tick();
      chk("coll_pulse", bus.press_pulse, 4'b0001);
      do_step();
      chk("coll_dir", bus.dir, 2'd2);
      bus.buttons = 4'b0000;
      repeat (6) tick();
      do_step();
      chk("coll_next", bus.dir, 2'd1);

      press_release(4'b1000);
      do_step();
      chk("to_down", bus.dir, 2'd3);
      bus.buttons = 4'b0001;
      repeat (7) tick();
      bus.game_rst = 1'b1;
      bus.step = 1'b1;
      tick();
      bus.game_rst = 1'b0;
      bus.step = 1'b0;
      chk("grst_dir", bus.dir, 2'd0);
      chk("grst_pressed", bus.pressed, 4'b0001);
      do_step();
      chk("grst_pend_clr", bus.dir, 2'd0);
      bus.buttons = 4'b0000;
      repeat (6) tick();
      chk("final_pressed", bus.pressed, 4'b0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
